// File: rtl/sdc_init_seq.sv
// SDRAM power-up initialisation sequencer: issues CKE, PALL, (EMRS, MRS with DLL reset),
// AUTO REFRESH and MRS, then raises init_done. Optional macro SDC_INIT_REINIT_EN adds reinit_req.
`timescale 1ns/1ps
module sdc_init_seq #(
    parameter logic [15:0] PWR_CYC = 16'd20000,
    parameter logic [3:0]  TRP     = 4'd3,
    parameter logic [3:0]  TRFC    = 4'd10,
    parameter logic [3:0]  TMRD    = 4'd2,
    parameter logic [2:0]  REF_NUM = 3'd2,
    parameter logic [15:0] DLL_CYC = 16'd200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sdc_sel,
`ifdef SDC_INIT_REINIT_EN
    input  logic       reinit_req,
`endif
    output logic       cke,
    output logic [2:0] cmd,
    output logic       mrs_addr,
    output logic       extMR,
    output logic       dll_rst,
    output logic       pall_a10,
    output logic       init_done,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_PWRUP = 4'd0,
        S_CKEON = 4'd1,
        S_PALL1 = 4'd2,
        S_EMRS  = 4'd3,
        S_MRS1  = 4'd4,
        S_PALL2 = 4'd5,
        S_REF   = 4'd6,
        S_MRS2  = 4'd7,
        S_DLLW  = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_PALL = 3'b010;
    localparam logic [2:0] CMD_REF  = 3'b001;
    localparam logic [2:0] CMD_MRS  = 3'b000;

    // The DDR MRS2 cycle itself is followed by DLLW, so DLLW covers DLL_CYC-1 cycles.
    localparam logic [15:0] DLL_LOAD = (DLL_CYC > 16'd1) ? (DLL_CYC - 16'd2) : 16'd0;

    function automatic logic [15:0] wait_load(input logic [3:0] t);
        return (t == 4'd0) ? 16'd0 : {12'd0, t - 4'd1};
    endfunction

    state_t      state_r, state_next_s;
    logic [15:0] cnt_r, cnt_next_s;
    logic [2:0]  ref_r, ref_next_s;
    logic        sel_r, sel_next_s;
    logic        enter_s;
    state_t      after_pall_s;

    logic        cke_next_s;
    logic [2:0]  cmd_next_s;
    logic        mrs_addr_next_s, extmr_next_s, dll_rst_next_s, pall_a10_next_s;
    logic        init_done_next_s;

    // Next-state, wait counter and registered-output decode.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        ref_next_s       = ref_r;
        sel_next_s       = sel_r;
        enter_s          = 1'b0;
        cmd_next_s       = CMD_NOP;
        mrs_addr_next_s  = 1'b0;
        extmr_next_s     = 1'b0;
        dll_rst_next_s   = 1'b0;
        pall_a10_next_s  = 1'b0;
        after_pall_s     = (REF_NUM != 3'd0) ? S_REF : S_MRS2;

        case (state_r)
            S_PWRUP: begin
                if (({1'b0, cnt_r} + 17'd1) >= {1'b0, PWR_CYC}) begin
                    state_next_s = S_CKEON;
                    cnt_next_s   = 16'd0;
                    sel_next_s   = sdc_sel;
                end else begin
                    cnt_next_s   = cnt_r + 16'd1;
                end
            end
            S_CKEON: begin
                state_next_s = S_PALL1;
                enter_s      = 1'b1;
            end
            S_DONE: begin
`ifdef SDC_INIT_REINIT_EN
                if (reinit_req) begin
                    state_next_s = S_PALL1;
                    enter_s      = 1'b1;
                end else begin
                    state_next_s = S_DONE;
                end
`else
                state_next_s = S_DONE;
`endif
            end
            S_PALL1, S_EMRS, S_MRS1, S_PALL2, S_REF, S_MRS2, S_DLLW: begin
                if (cnt_r != 16'd0) begin
                    cnt_next_s = cnt_r - 16'd1;
                end else begin
                    enter_s = 1'b1;
                    case (state_r)
                        S_PALL1: begin
                            state_next_s = sel_r ? after_pall_s : S_EMRS;
                            ref_next_s   = 3'd0;
                        end
                        S_EMRS:  state_next_s = S_MRS1;
                        S_MRS1:  state_next_s = S_PALL2;
                        S_PALL2: begin
                            state_next_s = after_pall_s;
                            ref_next_s   = 3'd0;
                        end
                        S_REF: begin
                            ref_next_s   = ref_r + 3'd1;
                            state_next_s = (({1'b0, ref_r} + 4'd1) < {1'b0, REF_NUM}) ? S_REF : S_MRS2;
                        end
                        S_MRS2:  state_next_s = sel_r ? S_DONE : S_DLLW;
                        S_DLLW:  state_next_s = S_DONE;
                        default: state_next_s = S_PWRUP;
                    endcase
                end
            end
            default: begin
                state_next_s = S_PWRUP;
                cnt_next_s   = 16'd0;
                ref_next_s   = 3'd0;
            end
        endcase

        // The command goes out in the cycle the new state is entered.
        if (enter_s) begin
            case (state_next_s)
                S_PALL1, S_PALL2: begin
                    cnt_next_s      = wait_load(TRP);
                    cmd_next_s      = CMD_PALL;
                    pall_a10_next_s = 1'b1;
                end
                S_EMRS: begin
                    cnt_next_s      = wait_load(TMRD);
                    cmd_next_s      = CMD_MRS;
                    mrs_addr_next_s = 1'b1;
                    extmr_next_s    = 1'b1;
                end
                S_MRS1: begin
                    cnt_next_s      = wait_load(TMRD);
                    cmd_next_s      = CMD_MRS;
                    mrs_addr_next_s = 1'b1;
                    dll_rst_next_s  = 1'b1;
                end
                S_REF: begin
                    cnt_next_s      = wait_load(TRFC);
                    cmd_next_s      = CMD_REF;
                end
                S_MRS2: begin
                    cnt_next_s      = sel_r ? wait_load(TMRD) : 16'd0;
                    cmd_next_s      = CMD_MRS;
                    mrs_addr_next_s = 1'b1;
                end
                S_DLLW:  cnt_next_s = DLL_LOAD;
                default: cnt_next_s = 16'd0;
            endcase
        end else begin
            cmd_next_s = CMD_NOP;
        end

        cke_next_s       = (state_next_s != S_PWRUP);
        init_done_next_s = (state_next_s == S_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_PWRUP;
            cnt_r     <= 16'd0;
            ref_r     <= 3'd0;
            sel_r     <= 1'b0;
            cke       <= 1'b0;
            cmd       <= CMD_NOP;
            mrs_addr  <= 1'b0;
            extMR     <= 1'b0;
            dll_rst   <= 1'b0;
            pall_a10  <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            ref_r     <= ref_next_s;
            sel_r     <= sel_next_s;
            cke       <= cke_next_s;
            cmd       <= cmd_next_s;
            mrs_addr  <= mrs_addr_next_s;
            extMR     <= extmr_next_s;
            dll_rst   <= dll_rst_next_s;
            pall_a10  <= pall_a10_next_s;
            init_done <= init_done_next_s;
            busy      <= ~init_done_next_s;
        end
    end

endmodule

// File: tb/tb_sdc_init_seq.sv
// Bench for sdc_init_seq: scenario tables feed an expected-command queue that is checked
// against the command stream, cke, init_done and busy of two differently configured instances.
`timescale 1ns/1ps
module tb_sdc_init_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst_n, a_sel, b_rst_n, b_sel, reinit_req, use_b;
    logic a_cke, a_mrs, a_ext, a_dll, a_a10, a_done, a_busy;
    logic b_cke, b_mrs, b_ext, b_dll, b_a10, b_done, b_busy;
    logic [2:0] a_cmd, b_cmd;

    sdc_init_seq #(.PWR_CYC(16'd20)) dut_a (
        .clk(clk), .reset_n(a_rst_n), .sdc_sel(a_sel),
`ifdef SDC_INIT_REINIT_EN
        .reinit_req(reinit_req),
`endif
        .cke(a_cke), .cmd(a_cmd), .mrs_addr(a_mrs), .extMR(a_ext), .dll_rst(a_dll),
        .pall_a10(a_a10), .init_done(a_done), .busy(a_busy));

    sdc_init_seq #(.PWR_CYC(16'd5), .TRP(4'd1), .REF_NUM(3'd0), .DLL_CYC(16'd5)) dut_b (
        .clk(clk), .reset_n(b_rst_n), .sdc_sel(b_sel),
`ifdef SDC_INIT_REINIT_EN
        .reinit_req(1'b0),
`endif
        .cke(b_cke), .cmd(b_cmd), .mrs_addr(b_mrs), .extMR(b_ext), .dll_rst(b_dll),
        .pall_a10(b_a10), .init_done(b_done), .busy(b_busy));

    logic       m_cke, m_done, m_busy, m_a10, m_mrs;
    logic [2:0] m_cmd;
    logic [3:0] m_flg;
    assign m_cke  = use_b ? b_cke  : a_cke;
    assign m_cmd  = use_b ? b_cmd  : a_cmd;
    assign m_done = use_b ? b_done : a_done;
    assign m_busy = use_b ? b_busy : a_busy;
    assign m_a10  = use_b ? b_a10  : a_a10;
    assign m_mrs  = use_b ? b_mrs  : a_mrs;
    assign m_flg  = use_b ? {b_mrs, b_ext, b_dll, b_a10} : {a_mrs, a_ext, a_dll, a_a10};

    // flg = {mrs_addr, extMR, dll_rst, pall_a10}; gap = cycles after previous command (or cke rise)
    typedef struct { logic [2:0] cmd; logic [3:0] flg; int gap; } vec_t;
    typedef struct { logic use_b; logic sel; int first; int count; int cke_cyc; int done_cyc; } scen_t;
    typedef struct { int cyc; logic [2:0] cmd; logic [3:0] flg; } exp_t;

    vec_t  vecs[16];
    scen_t scens[3];
    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic reset_check(input string name);
        check(name, {22'd0, m_cke, m_cmd, m_flg, m_done, m_busy}, {22'd0, 1'b0, 3'b111, 4'b0000, 1'b0, 1'b1});
    endtask

    task automatic set_rst(input logic b, input logic v);
        if (b) b_rst_n = v;
        else   a_rst_n = v;
    endtask

    task automatic run(input int s, input int abort_k, input bit reinit);
        scen_t sc;
        exp_t  e;
        int    c, base_cke, done_c;
        logic  legal;
        sc    = scens[s];
        use_b = sc.use_b;
        sb.delete();
        if (!reinit) begin
            @(negedge clk);
            set_rst(sc.use_b, 1'b0);
            if (sc.use_b) b_sel = sc.sel;
            else          a_sel = sc.sel;
            #1 reset_check("reset_state");
            @(negedge clk);
            set_rst(sc.use_b, 1'b1);
            base_cke = sc.cke_cyc;
            done_c   = sc.done_cyc;
        end else begin
            reinit_req = 1'b1;
            base_cke   = 0;
            done_c     = sc.done_cyc - sc.cke_cyc;
        end
        c = base_cke;
        for (int i = 0; i < sc.count; i++) begin
            c += vecs[sc.first + i].gap;
            sb.push_back('{c, vecs[sc.first + i].cmd, vecs[sc.first + i].flg});
        end
        for (int k = 1; k <= done_c + 4; k++) begin
            @(negedge clk);
            reinit_req = 1'b0;
            check("cke", {31'd0, m_cke}, {31'd0, (reinit || k >= base_cke) ? 1'b1 : 1'b0});
            check("init_done", {31'd0, m_done}, {31'd0, (k >= done_c) ? 1'b1 : 1'b0});
            check("busy", {31'd0, m_busy}, {31'd0, (k < done_c) ? 1'b1 : 1'b0});
            if (m_cmd != 3'b111) begin
                legal = (m_cmd inside {3'b010, 3'b001, 3'b000}) && !(m_a10 && m_mrs);
                check("cmd_legal", {31'd0, legal}, 32'd1);
                if (sb.size() == 0) begin
                    check("cmd_extra", {29'd0, m_cmd}, 32'd7);
                end else begin
                    e = sb.pop_front();
                    check("cmd_cycle", k, e.cyc);
                    check("cmd_code", {29'd0, m_cmd}, {29'd0, e.cmd});
                    check("cmd_flags", {28'd0, m_flg}, {28'd0, e.flg});
                end
            end else begin
                check("nop_flags", {28'd0, m_flg}, 32'd0);
            end
            if (k == abort_k) begin
                #2 set_rst(sc.use_b, 1'b0);
                #1 reset_check("async_reset");
                return;
            end
        end
        check("all_cmds_seen", sb.size(), 32'd0);
    endtask

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0; a_sel = 1'b0; b_sel = 1'b0;
        reinit_req = 1'b0; use_b = 1'b0;

        vecs[0]  = '{3'b010, 4'b0001, 1};
        vecs[1]  = '{3'b000, 4'b1100, 3};
        vecs[2]  = '{3'b000, 4'b1010, 2};
        vecs[3]  = '{3'b010, 4'b0001, 2};
        vecs[4]  = '{3'b001, 4'b0000, 3};
        vecs[5]  = '{3'b001, 4'b0000, 10};
        vecs[6]  = '{3'b000, 4'b1000, 10};
        vecs[7]  = '{3'b010, 4'b0001, 1};
        vecs[8]  = '{3'b001, 4'b0000, 3};
        vecs[9]  = '{3'b001, 4'b0000, 10};
        vecs[10] = '{3'b000, 4'b1000, 10};
        vecs[11] = '{3'b010, 4'b0001, 1};
        vecs[12] = '{3'b000, 4'b1100, 1};
        vecs[13] = '{3'b000, 4'b1010, 2};
        vecs[14] = '{3'b010, 4'b0001, 2};
        vecs[15] = '{3'b000, 4'b1000, 1};
        scens[0] = '{1'b0, 1'b0, 0, 7, 20, 251};
        scens[1] = '{1'b0, 1'b1, 7, 4, 20, 46};
        scens[2] = '{1'b1, 1'b0, 11, 5, 5, 17};

        run(0, 43, 1'b0);
        run(0, 0, 1'b0);
`ifdef SDC_INIT_REINIT_EN
        run(0, 0, 1'b1);
`endif
        run(1, 0, 1'b0);
        run(2, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
